// File: rtl/pio_rx_snoop.sv
// pio_rx_snoop: copies inbound RX AXIS TLP beats into a 72-bit FIFO and follows each TLP with GAP idle words
module pio_rx_snoop #(
  parameter int GAP = 3
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic [63:0] m_axis_rx_tdata,
  input  logic [7:0]  m_axis_rx_tkeep,
  input  logic        m_axis_rx_tlast,
  input  logic        m_axis_rx_tvalid,
  output logic        m_axis_rx_tready,
  input  logic        snoop_en,
  output logic [71:0] din,
  output logic        wr_en,
  input  logic        full,
  output logic [1:0]  last_fmt,
  output logic [4:0]  last_type,
  output logic [9:0]  last_length,
  output logic [7:0]  tlp_pktcount,
  output logic [7:0]  drop_pktcount
);
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_DROP, S_GAP} state_t;
  localparam logic [2:0] G = 3'(GAP);
  state_t state, state_nx;
  logic [2:0] gap_cnt, gap_cnt_nx;
  logic acc, first, cap, cap_end, drop_end, wr;
  // Handshake, capture decode and next state; tready closes during idle words and while in reset
  always_comb begin
    m_axis_rx_tready = sys_rst_n && (state == S_DROP || (state != S_GAP && !full));
    acc = m_axis_rx_tvalid && m_axis_rx_tready;
    first = acc && state == S_IDLE;
    cap = (first && snoop_en) || (acc && state == S_DATA);
    cap_end = cap && m_axis_rx_tlast;
    drop_end = acc && m_axis_rx_tlast && ((first && !snoop_en) || state == S_DROP);
    wr = cap || (state == S_GAP && !full);
    state_nx = state;
    gap_cnt_nx = gap_cnt;
    if (cap_end) begin
      state_nx = G != 3'd0 ? S_GAP : S_IDLE;
      gap_cnt_nx = G;
    end else if (first)
      state_nx = m_axis_rx_tlast ? S_IDLE : snoop_en ? S_DATA : S_DROP;
    else if (drop_end)
      state_nx = S_IDLE;
    else if (state == S_GAP && !full) begin
      gap_cnt_nx = gap_cnt - 3'd1;
      state_nx = gap_cnt == 3'd1 ? S_IDLE : S_GAP;
    end
  end
  // State, FIFO write port, header latch and packet counters
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= S_IDLE;
      gap_cnt <= 3'd0;
      wr_en <= 1'b0;
      din <= 72'h0;
      last_fmt <= 2'd0;
      last_type <= 5'd0;
      last_length <= 10'd0;
      tlp_pktcount <= 8'd0;
      drop_pktcount <= 8'd0;
    end else begin
      state <= state_nx;
      gap_cnt <= gap_cnt_nx;
      wr_en <= wr;
      if (wr) din <= state == S_GAP ? 72'h0 : {m_axis_rx_tkeep, m_axis_rx_tdata};
      if (first && snoop_en) begin
        last_fmt <= m_axis_rx_tdata[30:29];
        last_type <= m_axis_rx_tdata[28:24];
        last_length <= m_axis_rx_tdata[9:0];
      end
      if (cap_end) tlp_pktcount <= tlp_pktcount + 8'd1;
      if (drop_end) drop_pktcount <= drop_pktcount + 8'd1;
    end
  end
endmodule

// File: tb/tb_pio_rx_snoop.sv
// tb_pio_rx_snoop: table-driven and scoreboard check of pio_rx_snoop at GAP=3 and GAP=0
module tb_pio_rx_snoop;
  localparam int GAP = 3;
  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        e;
    logic        f;
    int          s;
    logic        c;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [63:0] tdata = '0;
  logic [7:0] tkeep = '0;
  logic tlast = 1'b0, tvalid = 1'b0, tvalid0 = 1'b0, snoop_en = 1'b0, full = 1'b0;
  logic tready, wr_en, tready0, wr_en0;
  logic [71:0] din, din0;
  logic [1:0] fmt, fmt0;
  logic [4:0] typ, typ0;
  logic [9:0] len, len0;
  logic [7:0] tlp, drop, tlp0, drop0;
  logic [7:0] exp_tlp = 8'd0, exp_drop = 8'd0, saved;
  logic [71:0] q[$];
  logic [63:0] prev;
  int checks = 0, errors = 0;
  vec_t tbl[12];
  always #5 clk = ~clk;
  pio_rx_snoop #(.GAP(GAP)) u3 (
    .clk(clk), .sys_rst_n(rst_n), .m_axis_rx_tdata(tdata), .m_axis_rx_tkeep(tkeep),
    .m_axis_rx_tlast(tlast), .m_axis_rx_tvalid(tvalid), .m_axis_rx_tready(tready),
    .snoop_en(snoop_en), .din(din), .wr_en(wr_en), .full(full), .last_fmt(fmt),
    .last_type(typ), .last_length(len), .tlp_pktcount(tlp), .drop_pktcount(drop)
  );
  pio_rx_snoop #(.GAP(0)) u0 (
    .clk(clk), .sys_rst_n(rst_n), .m_axis_rx_tdata(tdata), .m_axis_rx_tkeep(tkeep),
    .m_axis_rx_tlast(tlast), .m_axis_rx_tvalid(tvalid0), .m_axis_rx_tready(tready0),
    .snoop_en(snoop_en), .din(din0), .wr_en(wr_en0), .full(full), .last_fmt(fmt0),
    .last_type(typ0), .last_length(len0), .tlp_pktcount(tlp0), .drop_pktcount(drop0)
  );
  task automatic chk(input string n, input logic [71:0] a, input logic [71:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, a, e);
    end
  endtask
  // Scoreboard: every FIFO write of the GAP=3 instance must match the next expected word
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (q.size() == 0) chk("unexpected_write", din, 72'hx);
      else chk("din", din, q.pop_front());
    end
  end
  task automatic send(input vec_t v);
    int w;
    @(negedge clk);
    tdata = v.d; tkeep = v.k; tlast = v.l; snoop_en = v.e; tvalid = 1'b1;
    full = v.s > 0 ? 1'b1 : v.f;
    for (int i = 0; i < v.s; i++) begin
      #1 chk("stall_ready", tready, 0);
      @(negedge clk);
    end
    full = v.f;
    #1;
    if (v.f) chk("drop_ready", tready, 1);
    w = 0;
    while (!tready && w < 40) begin
      @(negedge clk);
      #1 w++;
    end
    if (!tready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got 0 exp 1");
    end else begin
      if (v.c) q.push_back({v.k, v.d});
      if (v.c && v.l) for (int i = 0; i < GAP; i++) q.push_back(72'h0);
      if (v.l) begin
        if (v.c) exp_tlp++;
        else exp_drop++;
      end
      @(posedge clk);
      #1;
      if (v.l) begin
        chk("tlp_pktcount", tlp, exp_tlp);
        chk("drop_pktcount", drop, exp_drop);
      end
    end
    tvalid = 1'b0;
    full = 1'b0;
  endtask
  initial begin
    tbl[0]  = '{64'h0000000F_40000001, 8'hFF, 1'b0, 1'b1, 1'b0, 0, 1'b1};
    tbl[1]  = '{64'h00000000_DEADBEEF, 8'h0F, 1'b1, 1'b1, 1'b0, 0, 1'b1};
    tbl[2]  = '{64'hA5A5A5A5_40000003, 8'hFF, 1'b0, 1'b1, 1'b0, 0, 1'b1};
    tbl[3]  = '{64'h11111111_22222222, 8'hFF, 1'b0, 1'b1, 1'b0, 0, 1'b1};
    tbl[4]  = '{64'h33333333_44444444, 8'hFF, 1'b0, 1'b1, 1'b0, 2, 1'b1};
    tbl[5]  = '{64'h55555555_66666666, 8'h0F, 1'b1, 1'b1, 1'b0, 0, 1'b1};
    tbl[6]  = '{64'h0000000A_5F0000FF, 8'hFF, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    tbl[7]  = '{64'h77777777_88888888, 8'hFF, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    tbl[8]  = '{64'h99999999_AAAAAAAA, 8'h03, 1'b1, 1'b1, 1'b1, 0, 1'b0};
    tbl[9]  = '{64'h12345678_7F000155, 8'hFF, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    tbl[10] = '{64'h00000000_04000002, 8'hFF, 1'b0, 1'b1, 1'b0, 0, 1'b1};
    tbl[11] = '{64'hCAFEF00D_0BADBEEF, 8'hFF, 1'b1, 1'b0, 1'b0, 0, 1'b1};
    #1 rst_n = 1'b0;
    #2;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_din", din, 72'h0);
    chk("rst_tready", tready, 0);
    chk("rst_tlp", tlp, 0);
    chk("rst_drop", drop, 0);
    chk("rst_last", {fmt, typ, len}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(tbl[i]);
      if (i == 1) begin
        for (int j = 0; j < GAP; j++) begin
          chk("gap_ready", tready, 0);
          @(posedge clk);
          #1;
        end
        chk("gap_end_ready", tready, 1);
        chk("last_fmt", fmt, 2);
        chk("last_type", typ, 0);
        chk("last_length", len, 1);
      end
    end
    chk("last_hdr_after_drop", {fmt, typ, len}, {2'd0, 5'd4, 10'd2});
    @(negedge clk);
    tvalid0 = 1'b1; tlast = 1'b1; snoop_en = 1'b1; tkeep = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      #1 chk("b2b_ready", tready0, 1);
      if (i > 0) begin
        chk("b2b_wr_en", wr_en0, 1);
        chk("b2b_din", din0, {8'hFF, prev});
      end
      prev = {32'hB2B00000 + 32'(i), 32'h00000001};
      tdata = prev;
      @(negedge clk);
    end
    tvalid0 = 1'b0;
    chk("b2b_last_wr", wr_en0, 1);
    chk("b2b_last_din", din0, {8'hFF, prev});
    @(negedge clk);
    chk("b2b_no_idle", wr_en0, 0);
    chk("b2b_count", tlp0, 6);
    chk("b2b_drop", drop0, 0);
    saved = exp_tlp;
    for (int j = 0; j < 256; j++)
      send('{{32'hC0DE0000, 32'(j)}, 8'hFF, 1'b1, 1'b1, 1'b0, 0, 1'b1});
    chk("wrap_tlp", tlp, saved);
    chk("wrap_drop", drop, exp_drop);
    send('{64'h0000000F_40000003, 8'hFF, 1'b0, 1'b1, 1'b0, 0, 1'b1});
    send('{64'hEEEEEEEE_FFFFFFFF, 8'hFF, 1'b0, 1'b1, 1'b0, 0, 1'b1});
    @(negedge clk);
    tdata = 64'hBAD0BAD0_BAD0BAD0; tlast = 1'b0; tvalid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_tlp", tlp, 0);
    chk("mid_rst_drop", drop, 0);
    chk("mid_rst_tready", tready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tvalid = 1'b0;
    exp_tlp = 8'd0;
    exp_drop = 8'd0;
    send('{64'h00000000_45000004, 8'hFF, 1'b1, 1'b1, 1'b0, 0, 1'b1});
    chk("post_rst_length", len, 4);
    repeat (10) @(negedge clk);
    chk("queue_drained", 72'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
